// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Instruction-memory req/ack read bus between fetch_unit and imem.
// Revision : 1.0
// ============================================================================
interface fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction-fetch stage owning PC and IR; req/ack imem reads.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              TIMEOUT  = 15
) (
   input  wire logic            clk,
   input  wire logic            reset,
   input  wire logic            load_ir,
   input  wire logic            load_pc,
   input  wire logic            pc_next_sel,
   input  wire logic            pc_adder_sel,
   input  wire logic [XLEN-1:0] imm,
   input  wire logic [XLEN-1:0] alu_result,
   fetch_unit_if.master         imem,
   output logic [31:0]          ir,
   output logic [6:0]           opcode,
   output logic [XLEN-1:0]      pc,
   output logic [XLEN-1:0]      pc_plus4,
   output logic                 fetch_busy,
   output logic                 fetch_valid,
   output logic                 fetch_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ERR  = 2'd2
   } state_t;

   localparam logic [7:0]  c_timeout_last = 8'(TIMEOUT - 1);
   localparam logic [31:0] c_nop          = 32'h0000_0013;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_start;
   logic            w_done;
   logic [7:0]      r_wait_cnt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_imem_addr;
   logic [31:0]     r_ir;
   logic            r_fetch_valid;
   logic [XLEN-1:0] w_adder;
   logic [XLEN-1:0] w_pc_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Ack wins over timeout when both land on the same edge.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (load_ir) begin
               if (r_pc[1:0] == 2'b00) begin
                  w_state_nxt = REQ;
                  w_start     = 1'b1;
               end else begin
                  w_state_nxt = ERR;
               end
            end
         end
         REQ: begin
            if (imem.imem_ack) begin
               w_state_nxt = IDLE;
               w_done      = 1'b1;
            end else if (r_wait_cnt == c_timeout_last) begin
               w_state_nxt = ERR;
            end
         end
         ERR: begin
            w_state_nxt = ERR;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign w_adder  = r_pc + (pc_adder_sel ? imm : XLEN'(4));
   assign w_pc_nxt = pc_next_sel ? {alu_result[XLEN-1:1], 1'b0} : w_adder;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc          <= RESET_PC;
         r_imem_addr   <= '0;
         r_ir          <= c_nop;
         r_wait_cnt    <= '0;
         r_fetch_valid <= 1'b0;
      end else begin
         r_fetch_valid <= w_done;
         if (w_start) begin
            r_imem_addr <= r_pc;
            r_wait_cnt  <= '0;
         end else if (r_state == REQ && !imem.imem_ack) begin
            r_wait_cnt  <= r_wait_cnt + 8'd1;
         end
         if (w_done) begin
            r_ir <= imem.imem_rdata;
         end
         // The request address is already latched, so a PC change mid-fetch is safe.
         if (load_pc && r_state != ERR) begin
            r_pc <= w_pc_nxt;
         end
      end
   end

   assign imem.imem_req  = (r_state == REQ);
   assign imem.imem_addr = r_imem_addr;
   assign ir             = r_ir;
   assign opcode         = r_ir[6:0];
   assign pc             = r_pc;
   assign pc_plus4       = r_pc + XLEN'(4);
   assign fetch_busy     = (r_state == REQ);
   assign fetch_valid    = r_fetch_valid;
   assign fetch_err      = (r_state == ERR);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;
   localparam int          XLEN     = 32;
   localparam int          TIMEOUT  = 15;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load_ir = 1'b0;
   logic        load_pc = 1'b0;
   logic        pc_next_sel = 1'b0;
   logic        pc_adder_sel = 1'b0;
   logic [31:0] imm = '0;
   logic [31:0] alu_result = '0;
   logic [31:0] ir;
   logic [6:0]  opcode;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_busy;
   logic        fetch_valid;
   logic        fetch_err;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] m_pc;
   logic [31:0] m_ir;

   fetch_unit_if #(.XLEN(XLEN)) imem_bus ();

   fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .load_ir     (load_ir),
      .load_pc     (load_pc),
      .pc_next_sel (pc_next_sel),
      .pc_adder_sel(pc_adder_sel),
      .imm         (imm),
      .alu_result  (alu_result),
      .imem        (imem_bus),
      .ir          (ir),
      .opcode      (opcode),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .fetch_busy  (fetch_busy),
      .fetch_valid (fetch_valid),
      .fetch_err   (fetch_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic nsel,
                                               input logic asel, input logic [31:0] im,
                                               input logic [31:0] alu);
      if (nsel) return alu & ~32'h1;
      return cur + (asel ? im : 32'd4);
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      load_ir = 0; load_pc = 0; pc_next_sel = 0; pc_adder_sel = 0;
      imem_bus.imem_ack = 0; imem_bus.imem_rdata = '0;
      reset = 0;
      cycle(); cycle();
      reset = 1;
      m_pc = RESET_PC;
      m_ir = 32'h0000_0013;
   endtask

   // Moves the PC to an absolute target through the imm adder path.
   task automatic set_pc(input logic [31:0] target);
      load_pc = 1; pc_next_sel = 0; pc_adder_sel = 1; imm = target - m_pc;
      cycle();
      load_pc = 0;
      m_pc = target;
   endtask

   task automatic test_reset();
      load_ir = 0; load_pc = 0;
      imem_bus.imem_ack = 0; imem_bus.imem_rdata = '0;
      reset = 0;
      cycle(); cycle();
      vectors++; if (pc !== RESET_PC) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", pc, RESET_PC); end
      vectors++; if (ir !== 32'h13) begin miscompares++; $display("FAIL reset_ir: got %h expected %h", ir, 32'h13); end
      vectors++; if (opcode !== 7'b0010011) begin miscompares++; $display("FAIL reset_opcode: got %b expected 0010011", opcode); end
      vectors++; if ({imem_bus.imem_req, fetch_busy, fetch_valid, fetch_err} !== 4'b0000) begin miscompares++;
         $display("FAIL reset_flags: got req/busy/valid/err=%b expected 0000", {imem_bus.imem_req, fetch_busy, fetch_valid, fetch_err}); end
      vectors++; if (imem_bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", imem_bus.imem_addr); end
      reset = 1;
      m_pc = RESET_PC;
      m_ir = 32'h0000_0013;
   endtask

   task automatic test_zero_wait();
      load_ir = 1;
      cycle();
      load_ir = 0;
      vectors++; if (imem_bus.imem_req !== 1'b1 || fetch_busy !== 1'b1 || imem_bus.imem_addr !== m_pc) begin miscompares++;
         $display("FAIL zw_req: got req=%b busy=%b addr=%h expected 1 1 %h", imem_bus.imem_req, fetch_busy, imem_bus.imem_addr, m_pc); end
      imem_bus.imem_ack = 1; imem_bus.imem_rdata = 32'h0000_0033;
      cycle();
      imem_bus.imem_ack = 0;
      m_ir = 32'h0000_0033;
      vectors++; if (ir !== m_ir || opcode !== 7'b0110011) begin miscompares++;
         $display("FAIL zw_ir: got ir=%h opcode=%b expected %h 0110011", ir, opcode, m_ir); end
      vectors++; if (fetch_valid !== 1'b1 || imem_bus.imem_req !== 1'b0 || pc !== m_pc) begin miscompares++;
         $display("FAIL zw_done: got valid=%b req=%b pc=%h expected 1 0 %h", fetch_valid, imem_bus.imem_req, pc, m_pc); end
      cycle();
      vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL zw_valid_pulse: got %b expected 0", fetch_valid); end
   endtask

   task automatic test_wait_states();
      set_pc(32'h10);
      for (int it = 0; it < 5; it++) begin
         int          n;
         logic [31:0] addr_exp;
         logic [31:0] data;
         n = (it == 0) ? 3 : int'($urandom_range(1, 10));
         data = $urandom;
         addr_exp = m_pc;
         load_ir = 1;
         cycle();
         load_ir = 0;
         for (int j = 0; j <= n; j++) begin
            vectors++; if (imem_bus.imem_req !== 1'b1 || fetch_busy !== 1'b1 || imem_bus.imem_addr !== addr_exp) begin miscompares++;
               $display("FAIL ws_hold it%0d c%0d: got req=%b busy=%b addr=%h expected 1 1 %h", it, j, imem_bus.imem_req, fetch_busy, imem_bus.imem_addr, addr_exp); end
            if (j == n) begin
               imem_bus.imem_ack = 1; imem_bus.imem_rdata = data;
            end else begin
               load_ir = 1'($urandom_range(0, 1));
               load_pc = 1'($urandom_range(0, 1));
               pc_next_sel = 0; pc_adder_sel = 1;
               imm = 32'($urandom_range(0, 63)) << 2;
               if (load_pc) m_pc = ref_next_pc(m_pc, 1'b0, 1'b1, imm, alu_result);
            end
            cycle();
            load_ir = 0; load_pc = 0; imem_bus.imem_ack = 0;
         end
         m_ir = data;
         vectors++; if (ir !== m_ir || fetch_valid !== 1'b1 || imem_bus.imem_req !== 1'b0 || pc !== m_pc) begin miscompares++;
            $display("FAIL ws_done it%0d: got ir=%h valid=%b req=%b pc=%h expected %h 1 0 %h", it, ir, fetch_valid, imem_bus.imem_req, pc, m_ir, m_pc); end
      end
      imem_bus.imem_ack = 1; imem_bus.imem_rdata = ~m_ir;
      cycle();
      imem_bus.imem_ack = 0;
      vectors++; if (ir !== m_ir || imem_bus.imem_req !== 1'b0) begin miscompares++;
         $display("FAIL stray_ack: got ir=%h req=%b expected %h 0", ir, imem_bus.imem_req, m_ir); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         int          n;
         logic [31:0] addr_exp;
         logic [31:0] data;
         n = int'($urandom_range(0, 1));
         data = $urandom;
         addr_exp = m_pc;
         load_ir = 1;
         if (i == 0) begin
            load_pc = 1; pc_next_sel = 0; pc_adder_sel = 0;
            m_pc = ref_next_pc(m_pc, 1'b0, 1'b0, imm, alu_result);
         end
         cycle();
         load_ir = 0; load_pc = 0;
         for (int j = 0; j <= n; j++) begin
            vectors++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== addr_exp) begin miscompares++;
               $display("FAIL b2b_req f%0d c%0d: got req=%b addr=%h expected 1 %h", i, j, imem_bus.imem_req, imem_bus.imem_addr, addr_exp); end
            if (j == n) begin imem_bus.imem_ack = 1; imem_bus.imem_rdata = data; end
            cycle();
            imem_bus.imem_ack = 0;
         end
         m_ir = data;
         vectors++; if (ir !== m_ir || fetch_valid !== 1'b1 || pc !== m_pc) begin miscompares++;
            $display("FAIL b2b_ir f%0d: got ir=%h valid=%b pc=%h expected %h 1 %h", i, ir, fetch_valid, pc, m_ir, m_pc); end
      end
   endtask

   task automatic test_pc_update();
      logic        t_nsel[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic        t_asel[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] t_imm[5]  = '{32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFE0, 32'h0, 32'h0};
      logic [31:0] t_exp[5]  = '{32'h18, 32'h1C, 32'hFFFF_FFFC, 32'h0, 32'h104};
      set_pc(32'h20);
      vectors++; if (pc !== 32'h20) begin miscompares++; $display("FAIL pc_setup: got %h expected 00000020", pc); end
      for (int s = 0; s < 5; s++) begin
         load_pc = 1; pc_next_sel = t_nsel[s]; pc_adder_sel = t_asel[s];
         imm = t_imm[s]; alu_result = 32'h0000_0105;
         cycle();
         load_pc = 0;
         m_pc = t_exp[s];
         vectors++; if (pc !== t_exp[s] || pc_plus4 !== t_exp[s] + 32'd4) begin miscompares++;
            $display("FAIL pc_step%0d: got pc=%h plus4=%h expected %h %h", s, pc, pc_plus4, t_exp[s], t_exp[s] + 32'd4); end
      end
      for (int r = 0; r < 10; r++) begin
         load_pc = 1'($urandom_range(0, 3) != 0);
         pc_next_sel = 1'($urandom_range(0, 1));
         pc_adder_sel = 1'($urandom_range(0, 1));
         imm = $urandom; alu_result = $urandom;
         if (load_pc) m_pc = ref_next_pc(m_pc, pc_next_sel, pc_adder_sel, imm, alu_result);
         cycle();
         load_pc = 0;
         vectors++; if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || fetch_err !== 1'b0) begin miscompares++;
            $display("FAIL pc_rand%0d: got pc=%h plus4=%h err=%b expected %h %h 0", r, pc, pc_plus4, fetch_err, m_pc, m_pc + 32'd4); end
      end
   endtask

   task automatic test_misaligned();
      apply_reset();
      set_pc(32'h102);
      vectors++; if (pc !== 32'h102 || fetch_err !== 1'b0) begin miscompares++;
         $display("FAIL mis_pc: got pc=%h err=%b expected 00000102 0", pc, fetch_err); end
      load_ir = 1;
      cycle();
      load_ir = 0;
      vectors++; if (imem_bus.imem_req !== 1'b0 || fetch_busy !== 1'b0 || fetch_err !== 1'b1) begin miscompares++;
         $display("FAIL mis_err: got req=%b busy=%b err=%b expected 0 0 1", imem_bus.imem_req, fetch_busy, fetch_err); end
      for (int i = 0; i < 3; i++) begin
         load_ir = 1; load_pc = 1; pc_next_sel = 0; pc_adder_sel = 0;
         imem_bus.imem_ack = 1; imem_bus.imem_rdata = $urandom;
         cycle();
         load_ir = 0; load_pc = 0; imem_bus.imem_ack = 0;
         vectors++; if (imem_bus.imem_req !== 1'b0 || fetch_err !== 1'b1 || pc !== m_pc || ir !== m_ir) begin miscompares++;
            $display("FAIL mis_sticky%0d: got req=%b err=%b pc=%h ir=%h expected 0 1 %h %h", i, imem_bus.imem_req, fetch_err, pc, ir, m_pc, m_ir); end
      end
   endtask

   task automatic test_timeout();
      apply_reset();
      set_pc(32'h40);
      load_ir = 1;
      cycle();
      load_ir = 0;
      for (int e = 1; e <= TIMEOUT; e++) begin
         cycle();
         if (e < TIMEOUT) begin
            if (fetch_err !== 1'b0 || imem_bus.imem_req !== 1'b1) begin miscompares++;
               $display("FAIL to_wait e%0d: got err=%b req=%b expected 0 1", e, fetch_err, imem_bus.imem_req); end
         end else begin
            if (fetch_err !== 1'b1 || imem_bus.imem_req !== 1'b0 || ir !== m_ir || fetch_valid !== 1'b0) begin miscompares++;
               $display("FAIL to_err: got err=%b req=%b ir=%h valid=%b expected 1 0 %h 0", fetch_err, imem_bus.imem_req, ir, fetch_valid, m_ir); end
         end
         vectors++;
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      set_pc(32'h80);
      load_ir = 1;
      cycle();
      load_ir = 0;
      cycle();
      vectors++; if (imem_bus.imem_req !== 1'b1 || pc !== 32'h80) begin miscompares++;
         $display("FAIL ar_pre: got req=%b pc=%h expected 1 00000080", imem_bus.imem_req, pc); end
      #2 reset = 0;
      #1;
      vectors++; if (imem_bus.imem_req !== 1'b0 || fetch_busy !== 1'b0 || pc !== RESET_PC || ir !== 32'h13) begin miscompares++;
         $display("FAIL ar_async: got req=%b busy=%b pc=%h ir=%h expected 0 0 %h 00000013", imem_bus.imem_req, fetch_busy, pc, ir, RESET_PC); end
      cycle();
      reset = 1;
      m_pc = RESET_PC;
      m_ir = 32'h0000_0013;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      imem_bus.imem_ack = 1'b0;
      imem_bus.imem_rdata = '0;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_back_to_back();
      test_pc_update();
      test_misaligned();
      test_timeout();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of the multicycle control unit `uc_asm`. It owns the PC and the instruction register, and runs a req/ack read transaction against instruction memory whenever the control unit raises `load_ir`. It updates the PC on `load_pc` according to `pc_next_sel`/`pc_adder_sel`, and presents `opcode` plus the full `ir` back to the control unit and datapath.

## Interface
- `XLEN`, default 32: PC and address width.
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `TIMEOUT`, default 15: maximum wait cycles for `imem_ack` before error; range 1..255.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted).
- `load_ir`  in  1  from control unit; start a fetch at the current PC.
- `load_pc`  in  1  from control unit; update the PC this edge.
- `pc_next_sel`  in  1  0 = adder result, 1 = `alu_result & ~1` (jalr).
- `pc_adder_sel`  in  1  adder operand: 0 = 4, 1 = `imm`.
- `imm`  in  XLEN  sign-extended branch/jal immediate.
- `alu_result`  in  XLEN  jalr target from the ALU.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  XLEN  read address; stable while `imem_req`=1.
- `imem_ack`  in  1  memory has valid `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word.
- `ir`  out  32  instruction register.
- `opcode`  out  7  `ir[6:0]`, combinational from `ir`.
- `pc`  out  XLEN  address of the instruction held in `ir`.
- `pc_plus4`  out  XLEN  `pc + 4`, combinational, for the jal/jalr link.
- `fetch_busy`  out  1  high in REQ state.
- `fetch_valid`  out  1  one-cycle pulse after `ir` is updated.
- `fetch_err`  out  1  sticky error: misaligned fetch or timeout.

## Operation
- States: IDLE, REQ, ERR. Reset enters IDLE.
- IDLE:
  - `load_ir`=1 with `pc[1:0]`=0: latch `imem_addr`<=`pc`, clear the wait counter, go to REQ.
  - `load_ir`=1 with `pc[1:0]`≠0: no request is issued; set `fetch_err`, go to ERR.
- REQ:
  - `imem_req`=1.
  - `imem_ack`=1 at an edge: `ir`<=`imem_rdata`, `fetch_valid`<=1 for the next cycle, go to IDLE.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT` without an ack: set `fetch_err`, go to ERR, and leave `ir` unchanged.
  - `load_ir` in REQ is ignored; it does not restart or extend the transaction.
- ERR: terminal. `imem_req`=0 and all inputs are ignored until reset.
- PC update on `load_pc`=1, in any state including REQ:
  - adder = `pc` + (`pc_adder_sel` ? `imm` : 4), modulo 2^XLEN with wrap-around.
  - `pc` <= `pc_next_sel` ? {`alu_result`[XLEN-1:1], 1'b0} : adder.
  - The in-flight fetch is unaffected because `imem_addr` was latched at fetch start.
- `load_ir` and `load_pc` together in IDLE: the fetch uses the old `pc`; the PC updates on the same edge.
- Misalignment is checked only at fetch start. A misaligned `load_pc` result alone raises no error.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `ir`=32'h0000_0013 (so `opcode`=7'b0010011), `imem_addr`=0.
  - `imem_req`=0, `fetch_busy`=0, `fetch_valid`=0, `fetch_err`=0, counter=0.
- `load_ir` sampled at edge k: `imem_req`=1 from edge k.
- Zero-wait memory (ack in the first REQ cycle): `ir` updates at edge k+1 and `fetch_valid`=1 during cycle k+1..k+2.
- N wait cycles: `ir` updates at edge k+1+N.
- Timeout: `fetch_err` rises at edge k+`TIMEOUT`.
- `imem_ack` outside REQ is ignored.
- Reset asserted mid-REQ: `imem_req` drops asynchronously, and all state returns to reset values immediately, without waiting for a clock edge.

## Test plan
1. Release reset, `RESET_PC`=0; pulse `load_ir`, ack in the next cycle with rdata 32'h0000_0033 -> `ir`=32'h33, `opcode`=7'b0110011, one-cycle `fetch_valid`, `pc`=0.
2. Fetch with 3 wait cycles at `pc`=0x10 -> `imem_addr`=0x10 held for 4 cycles, `fetch_busy` high for 4 cycles, `ir` loaded at the 4th edge.
3. `load_pc` with `pc_adder_sel`=1, `imm`=-8 (0xFFFF_FFF8), `pc`=0x20 -> `pc`=0x18. Then `pc_adder_sel`=0 -> 0x1C. Then `pc`=0xFFFF_FFFC with +4 -> wraps to 0.
4. `pc_next_sel`=1, `alu_result`=0x0000_0105 -> `pc`=0x104. `pc_plus4`=0x108 combinationally.
5. `load_pc` to 0x102 followed by `load_ir` -> no `imem_req`, `fetch_err`=1 sticky, and later `load_ir` pulses are ignored.
6. Timeout and reset cases:
   - No ack for `TIMEOUT`=15 cycles -> `fetch_err` at edge k+15 and `ir` unchanged.
   - Separately, reset=0 in the 2nd REQ cycle -> `imem_req`=0 immediately and `pc`=`RESET_PC`.
